// File: rtl/seq_divider8_if.sv
// Start/busy/done request bus for the sequential divider.
// The master drives the operands and start; the slave returns the results and status.
interface seq_divider8_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, A, B,
    input  Quotient, Remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output Quotient, Remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider8.sv
// Multi-cycle unsigned restoring divider: one shift-and-subtract step per clock,
// with the subtract done as an add of the inverted divisor plus one.
module seq_divider8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider8_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned SW = WIDTH + 2;
  localparam int unsigned XW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [RW-1:0]    r, r_d;
  logic [WIDTH-1:0] qsh, qsh_d;
  logic [WIDTH-1:0] bq, bq_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] quotient, quotient_d;
  logic [WIDTH-1:0] remainder, remainder_d;
  logic             busy, busy_d;
  logic             done, done_d;
  logic             dbz, dbz_d;

  logic [XW-1:0]    rq_sh;
  logic [SW-1:0]    sum;
  logic             no_borrow;
  logic [RW-1:0]    r_step;
  logic [WIDTH-1:0] q_step;

  // One restoring step: shift {R, Qsh}, trial-subtract the divisor, carry-out = no borrow.
  assign rq_sh     = {r, qsh} << 1;
  assign sum       = {1'b0, rq_sh[XW-1:WIDTH]} + {1'b0, ~{1'b0, bq}} + SW'(1);
  assign no_borrow = sum[SW-1];
  assign r_step    = no_borrow ? sum[RW-1:0] : rq_sh[XW-1:WIDTH];
  assign q_step    = rq_sh[WIDTH-1:0] | WIDTH'(no_borrow);

  // Next-state and datapath update.
  always_comb begin
    state_d     = state;
    r_d         = r;
    qsh_d       = qsh;
    bq_d        = bq;
    cnt_d       = cnt;
    quotient_d  = quotient;
    remainder_d = remainder;
    dbz_d       = dbz;
    done_d      = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          qsh_d   = bus.A;
          bq_d    = bus.B;
          r_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        // A zero divisor spends this single cycle here so done lands one edge after accept.
        if (bq == '0) begin
          state_d     = DONE;
          quotient_d  = '1;
          remainder_d = qsh;
          dbz_d       = 1'b1;
          done_d      = 1'b1;
        end else begin
          r_d   = r_step;
          qsh_d = q_step;
          cnt_d = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state_d     = DONE;
            quotient_d  = q_step;
            remainder_d = r_step[WIDTH-1:0];
            dbz_d       = 1'b0;
            done_d      = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r         <= '0;
      qsh       <= '0;
      bq        <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      state     <= state_d;
      r         <= r_d;
      qsh       <= qsh_d;
      bq        <= bq_d;
      cnt       <= cnt_d;
      quotient  <= quotient_d;
      remainder <= remainder_d;
      busy      <= busy_d;
      done      <= done_d;
      dbz       <= dbz_d;
    end
  end

  assign bus.Quotient    = quotient;
  assign bus.Remainder   = remainder;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8: scenario tasks with a queue of expected results.
module tb_seq_divider8;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  seq_divider8_if #(.WIDTH(W)) bus ();

  seq_divider8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Request accepted on the next rising edge (edge k); returns just after it, operands scrambled.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
  endtask

  // From the current falling edge, count falling edges until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus.Quotient, bus.Remainder} !== {W'(0), W'(0)}) begin
      n_err++;
      $display("FAIL reset_qr: got q=%0d r=%0d, want 0 0", bus.Quotient, bus.Remainder);
    end
    n_vec++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got busy=%b done=%b dbz=%b, want 0 0 0",
               bus.busy, bus.done, bus.div_by_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   lat;
    start_op(8'd100, 8'd7);
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_busy_rise: got %b, want 1", bus.busy);
    end
    wait_done(lat);
    n_vec++;
    if (lat != 8) begin
      n_err++;
      $display("FAIL basic_latency: got %0d, want 8", lat);
    end
    e = sb.pop_front();
    n_vec++;
    if ({bus.Quotient, bus.Remainder, bus.div_by_zero} !== {8'd14, 8'd2, 1'b0}) begin
      n_err++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
               bus.Quotient, bus.Remainder, bus.div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_fall: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] ta[4];
    logic [W-1:0] tb[4];
    exp_t e;
    int   lat;
    ta = '{8'd255, 8'd5, 8'd255, 8'd0};
    tb = '{8'd1,   8'd9, 8'd255, 8'd3};
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb[i]);
      @(negedge clk);
      wait_done(lat);
      e = sb.pop_front();
      n_vec++;
      if (lat != 8 || {bus.Quotient, bus.Remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
        n_err++;
        $display("FAIL boundary_%0d (%0d/%0d): got lat=%0d q=%0d r=%0d dbz=%b, want lat=8 q=%0d r=%0d dbz=%b",
                 i, ta[i], tb[i], lat, bus.Quotient, bus.Remainder, bus.div_by_zero, e.q, e.r, e.dbz);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    exp_t e;
    int   lat;
    start_op(8'd42, 8'd0);
    @(negedge clk);
    wait_done(lat);
    e = sb.pop_front();
    n_vec++;
    if (lat != 1 || {bus.Quotient, bus.Remainder, bus.div_by_zero} !== {8'd255, 8'd42, 1'b1}) begin
      n_err++;
      $display("FAIL div_zero: got lat=%0d q=%0d r=%0d dbz=%b, want lat=1 q=%0d r=%0d dbz=%b",
               lat, bus.Quotient, bus.Remainder, bus.div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b001) begin
      n_err++;
      $display("FAIL div_zero_after: got busy=%b done=%b dbz=%b, want 0 0 1",
               bus.busy, bus.done, bus.div_by_zero);
    end
    start_op(8'd9, 8'd3);
    @(negedge clk);
    wait_done(lat);
    e = sb.pop_front();
    n_vec++;
    if (lat != 8 || {bus.Quotient, bus.Remainder, bus.div_by_zero} !== {8'd3, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL div_zero_clear: got lat=%0d q=%0d r=%0d dbz=%b, want lat=8 q=%0d r=%0d dbz=%b",
               lat, bus.Quotient, bus.Remainder, bus.div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    logic stable;
    stable = 1'b1;
    start_op(8'd100, 8'd7);
    for (int j = 0; j <= 9; j++) begin
      @(negedge clk);
      if (j < 8 && (bus.done !== 1'b0 ||
                    {bus.Quotient, bus.Remainder, bus.div_by_zero} !== {8'd3, 8'd0, 1'b0}))
        stable = 1'b0;
      if (j == 2) begin
        bus.A     = 8'd50;
        bus.B     = 8'd5;
        bus.start = 1'b1;
      end
      if (j == 3) bus.start = 1'b0;
      if (j == 8) begin
        e = sb.pop_front();
        n_vec++;
        if (bus.done !== 1'b1 || {bus.Quotient, bus.Remainder} !== {8'd14, 8'd2}) begin
          n_err++;
          $display("FAIL b2b_first: got done=%b q=%0d r=%0d, want done=1 q=%0d r=%0d",
                   bus.done, bus.Quotient, bus.Remainder, e.q, e.r);
        end
        bus.A     = 8'd50;
        bus.B     = 8'd5;
        bus.start = 1'b1;
      end
      if (j == 9) begin
        n_vec++;
        if ({bus.busy, bus.done} !== 2'b00) begin
          n_err++;
          $display("FAIL b2b_ignore_in_done: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
      end
    end
    n_vec++;
    if (stable !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_hold: got stable=%b, want 1", stable);
    end
    // start is still high, so the IDLE edge that follows accepts 50/5.
    sb.push_back(model(8'd50, 8'd5));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    @(negedge clk);
    wait_done(lat);
    e = sb.pop_front();
    n_vec++;
    if (lat != 8 || {bus.Quotient, bus.Remainder, bus.div_by_zero} !== {8'd10, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d dbz=%b, want lat=8 q=%0d r=%0d dbz=%b",
               lat, bus.Quotient, bus.Remainder, bus.div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   lat;
    logic no_done;
    start_op(8'd200, 8'd3);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_vec++;
    if ({bus.Quotient, bus.Remainder, bus.busy, bus.done, bus.div_by_zero} !== {W'(0), W'(0), 3'b000}) begin
      n_err++;
      $display("FAIL async_reset: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
               bus.Quotient, bus.Remainder, bus.busy, bus.done, bus.div_by_zero);
    end
    no_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
    end
    n_vec++;
    if (no_done !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_discard: got quiet=%b, want 1", no_done);
    end
    start_op(8'd200, 8'd3);
    @(negedge clk);
    wait_done(lat);
    e = sb.pop_front();
    n_vec++;
    if (lat != 8 || {bus.Quotient, bus.Remainder, bus.div_by_zero} !== {8'd66, 8'd2, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset_rerun: got lat=%0d q=%0d r=%0d dbz=%b, want lat=8 q=%0d r=%0d dbz=%b",
               lat, bus.Quotient, bus.Remainder, bus.div_by_zero, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_random();
    exp_t         e;
    exp_t         prev;
    int           lat;
    logic         stable;
    logic [W-1:0] a;
    logic [W-1:0] b;
    prev = model(8'd200, 8'd3);
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = W'($urandom);
      b = W'($urandom_range(1, 255));
      start_op(a, b);
      @(negedge clk);
      stable = 1'b1;
      lat    = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
        if ({bus.Quotient, bus.Remainder, bus.div_by_zero} !== prev) stable = 1'b0;
        @(negedge clk);
        lat++;
      end
      e = sb.pop_front();
      n_vec++;
      if (lat != 8 || !stable || {bus.Quotient, bus.Remainder, bus.div_by_zero} !== e) begin
        n_err++;
        if (n_err < 20)
          $display("FAIL random_%0d (%0d/%0d): got lat=%0d stable=%b q=%0d r=%0d dbz=%b, want lat=8 stable=1 q=%0d r=%0d dbz=%b",
                   i, a, b, lat, stable, bus.Quotient, bus.Remainder, bus.div_by_zero, e.q, e.r, e.dbz);
      end
      prev = e;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog expired");
  end

endmodule
